// File: rtl/pc_alu_control.sv
// Single-cycle datapath slice: registered program counter, combinational
// opcode decode into control signals, and a combinational 32-bit ALU.
module pc_alu_control #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] jump_address,
  input  logic [5:0]  opcode,
  input  logic [5:0]  sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] pc_out,
  output logic        regDest,
  output logic        jump,
  output logic        branch,
  output logic        MemRead,
  output logic        MemtoReg,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic [1:0]  ALUOp,
  output logic [31:0] ans,
  output logic        zero
);

  localparam logic [31:0] PC_STEP_W = 32'(PC_STEP);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Control vector order: regDest,jump,branch,MemRead,MemtoReg,MemWrite,ALUSrc,RegWrite,ALUOp
  logic [9:0] ctrl;

  always_comb begin
    ctrl = 10'b0000000000;
    case (opcode)
      OP_RTYPE: ctrl = 10'b1000000110;
      OP_LW:    ctrl = 10'b0001101100;
      OP_SW:    ctrl = 10'b0000011000;
      OP_BEQ:   ctrl = 10'b0010000001;
      OP_ADDI:  ctrl = 10'b0000001100;
      OP_J:     ctrl = 10'b0100000000;
      default:  ctrl = 10'b0000000000;
    endcase
  end

  assign {regDest, jump, branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp} = ctrl;

  function automatic logic [31:0] slt_s(input logic signed [31:0] x,
                                        input logic signed [31:0] y);
    return (x < y) ? 32'd1 : 32'd0;
  endfunction

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  assign a_s = a;
  assign b_s = b;

  // Add/sub wrap naturally at 32 bits; no overflow detection.
  always_comb begin
    ans = 32'd0;
    case (ALUOp)
      2'b00: ans = a + b;
      2'b01: ans = a - b;
      2'b10: begin
        case (sel)
          FN_ADD:  ans = a + b;
          FN_SUB:  ans = a - b;
          FN_AND:  ans = a & b;
          FN_OR:   ans = a | b;
          FN_NOR:  ans = ~(a | b);
          FN_SLT:  ans = slt_s(a_s, b_s);
          default: ans = 32'd0;
        endcase
      end
      default: ans = 32'd0;
    endcase
  end

  assign zero = (ans == 32'd0);

  logic [31:0] pc_next;
  assign pc_next = jump ? jump_address : (pc + PC_STEP_W);

  // Only the PC is stateful; reset forces it asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_out <= RESET_PC;
    else     pc_out <= pc_next;
  end

endmodule

// File: tb/tb_pc_alu_control.sv
// Directed bench for pc_alu_control: reset, PC sequencing, jump, ALU ops and decode.
module tb_pc_alu_control;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] jump_address;
  logic [5:0]  opcode;
  logic [5:0]  sel;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] pc_out;
  logic        regDest, jump, branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite;
  logic [1:0]  ALUOp;
  logic [31:0] ans;
  logic        zero;

  int checks;
  int failures;

  pc_alu_control dut (
    .clk(clk), .rst(rst), .pc(pc), .jump_address(jump_address),
    .opcode(opcode), .sel(sel), .a(a), .b(b), .pc_out(pc_out),
    .regDest(regDest), .jump(jump), .branch(branch), .MemRead(MemRead),
    .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUSrc(ALUSrc),
    .RegWrite(RegWrite), .ALUOp(ALUOp), .ans(ans), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst = 1'b1; pc = 32'd0; jump_address = 32'd0; opcode = 6'b000000;
    sel = 6'b100000; a = 32'd0; b = 32'd0;
    #1;
    checks++;
    if (pc_out !== 32'd0) begin
      failures++; $display("FAIL reset_initial got=%h exp=%h", pc_out, 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; opcode = 6'b000010; jump_address = 32'h40;
    @(posedge clk); #1;
    checks++;
    if (pc_out !== 32'h40) begin
      failures++; $display("FAIL preload_40 got=%h exp=%h", pc_out, 32'h40);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (pc_out !== 32'd0) begin
      failures++; $display("FAIL reset_async got=%h exp=%h", pc_out, 32'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pc_out !== 32'd0) begin
      failures++; $display("FAIL reset_hold got=%h exp=%h", pc_out, 32'd0);
    end
  endtask

  task automatic test_sequential;
    @(negedge clk);
    rst = 1'b0; pc = 32'd0; opcode = 6'b000000;
    @(posedge clk); #1;
    checks++;
    if (pc_out !== 32'd4) begin
      failures++; $display("FAIL seq_first got=%h exp=%h", pc_out, 32'd4);
    end
    @(negedge clk);
    pc = 32'd4;
    @(posedge clk); #1;
    checks++;
    if (pc_out !== 32'd8) begin
      failures++; $display("FAIL seq_second got=%h exp=%h", pc_out, 32'd8);
    end
    @(negedge clk);
    pc = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    checks++;
    if (pc_out !== 32'd0) begin
      failures++; $display("FAIL seq_wrap got=%h exp=%h", pc_out, 32'd0);
    end
  endtask

  task automatic test_jump;
    @(negedge clk);
    opcode = 6'b000010; jump_address = 32'h100; pc = 32'd8;
    #1;
    checks++;
    if (jump !== 1'b1) begin
      failures++; $display("FAIL jump_flag got=%b exp=1", jump);
    end
    @(posedge clk); #1;
    checks++;
    if (pc_out !== 32'h100) begin
      failures++; $display("FAIL jump_target got=%h exp=%h", pc_out, 32'h100);
    end
    @(negedge clk);
    opcode = 6'b000100; pc = 32'h100; jump_address = 32'h200;
    @(posedge clk); #1;
    checks++;
    if (pc_out !== 32'h104) begin
      failures++; $display("FAIL beq_no_jump got=%h exp=%h", pc_out, 32'h104);
    end
  endtask

  task automatic test_alu;
    logic [31:0] exp_ans [7];
    logic [5:0]  fn      [7];
    logic [31:0] va      [7];
    logic [31:0] vb      [7];
    fn[0] = 6'b100010; va[0] = 32'd5;         vb[0] = 32'd3;         exp_ans[0] = 32'd2;
    fn[1] = 6'b100010; va[1] = 32'd7;         vb[1] = 32'd7;         exp_ans[1] = 32'd0;
    fn[2] = 6'b100000; va[2] = 32'h1234_0000; vb[2] = 32'h0000_5678; exp_ans[2] = 32'h1234_5678;
    fn[3] = 6'b100100; va[3] = 32'hF0F0_FF00; vb[3] = 32'h0FF0_F0F0; exp_ans[3] = 32'h00F0_F000;
    fn[4] = 6'b100101; va[4] = 32'hF000_0001; vb[4] = 32'h0000_0F00; exp_ans[4] = 32'hF000_0F01;
    fn[5] = 6'b100111; va[5] = 32'h0000_0000; vb[5] = 32'hFFFF_0000; exp_ans[5] = 32'h0000_FFFF;
    fn[6] = 6'b111111; va[6] = 32'd9;         vb[6] = 32'd9;         exp_ans[6] = 32'd0;
    opcode = 6'b000000;
    for (int i = 0; i < 7; i++) begin
      sel = fn[i]; a = va[i]; b = vb[i];
      #1;
      checks++;
      if (ans !== exp_ans[i] || zero !== (exp_ans[i] == 32'd0)) begin
        failures++;
        $display("FAIL alu_vec%0d got ans=%h zero=%b exp ans=%h zero=%b",
                 i, ans, zero, exp_ans[i], exp_ans[i] == 32'd0);
      end
    end
  endtask

  task automatic test_alu_boundary;
    opcode = 6'b000000;
    a = 32'hFFFF_FFFF; b = 32'd1; sel = 6'b100000;
    #1;
    checks++;
    if (ans !== 32'd0 || zero !== 1'b1) begin
      failures++; $display("FAIL add_wrap got ans=%h zero=%b exp ans=0 zero=1", ans, zero);
    end
    sel = 6'b101010;
    #1;
    checks++;
    if (ans !== 32'd1) begin
      failures++; $display("FAIL slt_neg got=%h exp=1", ans);
    end
    a = 32'd1; b = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (ans !== 32'd0 || zero !== 1'b1) begin
      failures++; $display("FAIL slt_pos got ans=%h zero=%b exp ans=0 zero=1", ans, zero);
    end
    a = 32'd0; b = 32'd1; sel = 6'b100010;
    #1;
    checks++;
    if (ans !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL sub_wrap got=%h exp=ffffffff", ans);
    end
    opcode = 6'b111111; a = 32'd10; b = 32'd20;
    #1;
    checks++;
    if (ans !== 32'd30) begin
      failures++; $display("FAIL undef_op_add got=%h exp=%h", ans, 32'd30);
    end
  endtask

  task automatic test_decode;
    logic [5:0] ops  [7];
    logic [9:0] exp  [7];
    logic [9:0] got;
    ops[0] = 6'b000000; exp[0] = 10'b1000000110;
    ops[1] = 6'b100011; exp[1] = 10'b0001101100;
    ops[2] = 6'b101011; exp[2] = 10'b0000011000;
    ops[3] = 6'b000100; exp[3] = 10'b0010000001;
    ops[4] = 6'b001000; exp[4] = 10'b0000001100;
    ops[5] = 6'b000010; exp[5] = 10'b0100000000;
    ops[6] = 6'b111111; exp[6] = 10'b0000000000;
    for (int i = 0; i < 7; i++) begin
      opcode = ops[i];
      #1;
      got = {regDest, jump, branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp};
      checks++;
      if (got !== exp[i]) begin
        failures++;
        $display("FAIL decode_op%b got=%b exp=%b", ops[i], got, exp[i]);
      end
    end
    opcode = 6'b000100; a = 32'h55; b = 32'h55; sel = 6'b000000;
    #1;
    checks++;
    if (ALUOp !== 2'b01 || zero !== 1'b1 || ans !== 32'd0) begin
      failures++; $display("FAIL beq_equal got ALUOp=%b zero=%b ans=%h exp ALUOp=01 zero=1 ans=0",
                           ALUOp, zero, ans);
    end
    b = 32'h50;
    #1;
    checks++;
    if (ans !== 32'h5 || zero !== 1'b0) begin
      failures++; $display("FAIL beq_diff got ans=%h zero=%b exp ans=5 zero=0", ans, zero);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_sequential();
    test_jump();
    test_alu();
    test_alu_boundary();
    test_decode();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_alu_control.md
PC_ALU_CONTROL -- requirements
Module: pc_alu_control

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the value pc_out takes on reset.
REQ-002 The block SHALL have parameter PC_STEP, default 4, giving the sequential PC increment in bytes.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 pc  input  32  current PC as selected by the surrounding datapath (sequential or branch target).
REQ-006 jump_address  input  32  absolute jump target, used when jump=1.
REQ-007 opcode  input  6  instruction bits [31:26].
REQ-008 sel  input  6  funct field, instruction bits [5:0].
REQ-009 a  input  32  ALU operand A.
REQ-010 b  input  32  ALU operand B.
REQ-011 pc_out  output  32  registered next PC.
REQ-012 regDest, jump, branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite  output  1 each  decoded control signals.
REQ-013 ALUOp  output  2  ALU operation class.
REQ-014 ans  output  32  ALU result.
REQ-015 zero  output  1  1 when ans == 0.

Function
REQ-016 Control decode SHALL be purely combinational from opcode.
REQ-017 Decode, as regDest,jump,branch,MemRead,MemtoReg,MemWrite,ALUSrc,RegWrite,ALUOp:
- 000000 R-type: 1,0,0,0,0,0,0,1,10
- 100011 lw: 0,0,0,1,1,0,1,1,00
- 101011 sw: 0,0,0,0,0,1,1,0,00
- 000100 beq: 0,0,1,0,0,0,0,0,01
- 001000 addi: 0,0,0,0,0,0,1,1,00
- 000010 j: 0,1,0,0,0,0,0,0,00
REQ-018 Any other opcode SHALL drive all control outputs to 0, ALUOp=00.
REQ-019 The ALU SHALL be purely combinational; ALUOp=00 SHALL compute a+b.
REQ-020 ALUOp=01 SHALL compute a-b.
REQ-021 ALUOp=10 SHALL decode sel:
- 100000 add
- 100010 sub
- 100100 and
- 100101 or
- 100111 nor
- 101010 slt, signed, result 32'd1 or 32'd0
REQ-022 An undefined sel with ALUOp=10, and ALUOp=11, SHALL give ans=0.
REQ-023 Add/sub SHALL wrap modulo 2^32 with no overflow flag or trap.
REQ-024 zero SHALL be combinational (ans == 32'd0), valid in the same cycle as ans.
REQ-025 On each rising clk with rst=0, pc_out SHALL load jump_address if jump=1, else pc + PC_STEP modulo 2^32.
REQ-026 PC update latency SHALL be one cycle; there is no stall or enable input.
REQ-027 jump SHALL override all other PC sources.
REQ-028 Branch-target selection SHALL NOT be part of this block; branch/zero are output only.

Reset
REQ-029 While rst=1, pc_out SHALL be RESET_PC immediately, without waiting for clk.
REQ-030 Reset SHALL hold pc_out regardless of clk edges, including reset asserted mid-cycle.
REQ-031 On the first rising clk after rst deasserts, pc_out SHALL update per REQ-025.
REQ-032 Control and ALU outputs SHALL have no reset and SHALL always track their inputs.

Verification
REQ-033 Assert rst=1 between clock edges with pc_out=32'h40 -> pc_out=0 immediately; hold across 2 edges -> stays 0.
REQ-034 Release rst, pc=0, opcode=000000 -> pc_out 4 after 1 edge; then pc=4 -> pc_out 8 after the next edge.
REQ-035 opcode=000010, jump_address=32'h100, pc=8 -> jump=1 and pc_out=32'h100 after one edge.
REQ-036 opcode=000000, a=5, b=3, sel=100010 -> ans=2, zero=0; a=b=7 -> ans=0, zero=1.
REQ-037 opcode=000000: a=32'hFFFF_FFFF, b=1, sel=100000 -> ans=0, zero=1; sel=101010 -> ans=1 (signed -1<1).
REQ-038 Opcodes 100011, 101011, 000100, and 111111 -> control vectors per REQ-017 and REQ-018; beq with a=b -> ALUOp=01, zero=1.
